// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback FSM with memory timeout.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        flag_z,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        reg_we,
    output logic        flag_we,
    output logic        alu_src_imm,
    output logic [3:0]  alu_op,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_BRZ   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;
    localparam logic [3:0] OP_NOP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam bit TMO_ENABLED = (MEM_TIMEOUT != 0);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] tmo_cnt;
    logic             run_q;
    logic             run_rise;
    logic             waiting;
    logic             timeout_hit;
    logic [3:0]       op;
    logic             is_alu;
    logic             unused_instr_bits;

    assign op                = instr[15:12];
    assign is_alu            = (op <= 4'h9);
    assign run_rise          = run & ~run_q;
    assign timeout_hit       = TMO_ENABLED && (tmo_cnt == TMO_LIMIT);
    assign state             = state_q;
    assign unused_instr_bits = ^instr[11:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run;
            tmo_cnt <= (waiting && TMO_ENABLED) ? tmo_cnt + 1'b1 : '0;
        end
    end

    // A handshake in the same cycle the counter hits its limit takes priority over the fault.
    always_comb begin
        state_d      = state_q;
        waiting      = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        reg_we       = 1'b0;
        flag_we      = 1'b0;
        alu_src_imm  = 1'b0;
        alu_op       = 4'h0;
        halted       = 1'b0;
        fault        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_rise) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                if (op == OP_HALT)     state_d = S_HALT;
                else if (op == OP_NOP) state_d = S_FETCH;
                else                   state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu) begin
                    alu_op      = op;
                    alu_src_imm = instr[0];
                    flag_we     = instr[1];
                    state_d     = S_WB;
                end else if (op == OP_LOAD || op == OP_STORE) begin
                    state_d = S_MEM;
                end else if (op == OP_BRZ) begin
                    pc_load = flag_z;
                    state_d = S_FETCH;
                end else begin
                    pc_load = (op == OP_JMP);
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op == OP_STORE);
                if (mem_ready) begin
                    state_d = (op == OP_STORE) ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (run_rise) state_d = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    logic        retire;
    logic [15:0] retired_q;

    // An instruction retires on the cycle it leaves its final state.
    assign retire = (state_q == S_WB)
                 || (state_q == S_EXEC && (op == OP_BRZ || op == OP_JMP))
                 || (state_q == S_MEM && op == OP_STORE && mem_ready)
                 || (state_q == S_DECODE && (op == OP_NOP || op == OP_HALT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 16'h0000;
        end else if (retire) begin
            retired_q <= retired_q + 16'h0001;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 16'h0000;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: cycle-by-cycle vector table plus
// hand-written timeout, handshake race, mid-fetch reset and halt sequences.
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] instr;
    logic        flag_z;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load;
    logic        reg_we, flag_we, alu_src_imm, halted, fault;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic [15:0] retired;
    logic [14:0] dut_outs;

    int errors = 0;
    int checks = 0;

    control_sequencer #(.MEM_TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .instr        (instr),
        .flag_z       (flag_z),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .reg_we       (reg_we),
        .flag_we      (flag_we),
        .alu_src_imm  (alu_src_imm),
        .alu_op       (alu_op),
        .halted       (halted),
        .fault        (fault),
        .state        (state),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_outs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load,
                       reg_we, flag_we, alu_src_imm, alu_op, halted, fault};

    localparam logic [14:0] MREQ = 15'h4000;
    localparam logic [14:0] MWE  = 15'h2000;
    localparam logic [14:0] MSEL = 15'h1000;
    localparam logic [14:0] IRL  = 15'h0800;
    localparam logic [14:0] PCI  = 15'h0400;
    localparam logic [14:0] PCL  = 15'h0200;
    localparam logic [14:0] RWE  = 15'h0100;
    localparam logic [14:0] FWE  = 15'h0080;
    localparam logic [14:0] AIMM = 15'h0040;
    localparam logic [14:0] HLT  = 15'h0002;
    localparam logic [14:0] FTCH = MREQ | IRL | PCI;

    typedef struct {
        logic        run;
        logic [15:0] instr;
        logic        flag_z;
        logic        mem_ready;
        logic [2:0]  state;
        logic [14:0] outs;
        logic [15:0] ret;
    } vec_t;

    vec_t vq[$];

    function automatic void addVec(input logic r, input logic [15:0] ins, input logic fz,
                                   input logic mr, input logic [2:0] st,
                                   input logic [14:0] o, input logic [15:0] rt);
        vec_t v;
        v.run = r; v.instr = ins; v.flag_z = fz; v.mem_ready = mr;
        v.state = st; v.outs = o; v.ret = rt;
        vq.push_back(v);
    endfunction

    function automatic logic [15:0] expRetired(input logic [15:0] count);
`ifdef SEQ_PERF_CNT_EN
        return count;
`else
        return 16'h0000 & count;
`endif
    endfunction

    // Inputs change just after the rising edge; outputs are sampled 2 time units later.
    task automatic applyStimulus(input logic r, input logic [15:0] ins,
                                 input logic fz, input logic mr);
        @(posedge clk);
        #1;
        run = r; instr = ins; flag_z = fz; mem_ready = mr;
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s[%0d] actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0; run = 1'b0; instr = 16'h0000; flag_z = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        doReset();

        addVec(0, 16'h0000, 0, 0, 3'd0, 15'h0,             16'd0);
        addVec(1, 16'h0000, 0, 0, 3'd0, 15'h0,             16'd0);
        addVec(1, 16'h1234, 0, 1, 3'd1, FTCH,              16'd0);
        addVec(0, 16'h1234, 0, 0, 3'd2, 15'h0,             16'd0);
        addVec(0, 16'h1234, 0, 0, 3'd3, 15'h0004,          16'd0);
        addVec(0, 16'h1234, 0, 0, 3'd5, RWE,               16'd0);
        addVec(0, 16'h1234, 0, 0, 3'd1, MREQ,              16'd1);
        addVec(0, 16'h5A03, 0, 1, 3'd1, FTCH,              16'd1);
        addVec(0, 16'h5A03, 0, 0, 3'd2, 15'h0,             16'd1);
        addVec(0, 16'h5A03, 0, 0, 3'd3, 15'h0014|FWE|AIMM, 16'd1);
        addVec(0, 16'h5A03, 0, 0, 3'd5, RWE,               16'd1);
        addVec(0, 16'hA000, 0, 1, 3'd1, FTCH,              16'd2);
        addVec(0, 16'hA000, 0, 0, 3'd2, 15'h0,             16'd2);
        addVec(0, 16'hA000, 0, 0, 3'd3, 15'h0,             16'd2);
        addVec(0, 16'hA000, 0, 0, 3'd4, MREQ|MSEL,         16'd2);
        addVec(0, 16'hA000, 0, 0, 3'd4, MREQ|MSEL,         16'd2);
        addVec(0, 16'hA000, 0, 0, 3'd4, MREQ|MSEL,         16'd2);
        addVec(0, 16'hA000, 0, 1, 3'd4, MREQ|MSEL,         16'd2);
        addVec(0, 16'hA000, 0, 0, 3'd5, RWE,               16'd2);
        addVec(0, 16'hB000, 0, 1, 3'd1, FTCH,              16'd3);
        addVec(0, 16'hB000, 0, 0, 3'd2, 15'h0,             16'd3);
        addVec(0, 16'hB000, 0, 0, 3'd3, 15'h0,             16'd3);
        addVec(0, 16'hB000, 0, 1, 3'd4, MREQ|MWE|MSEL,     16'd3);
        addVec(0, 16'hC000, 1, 1, 3'd1, FTCH,              16'd4);
        addVec(0, 16'hC000, 1, 0, 3'd2, 15'h0,             16'd4);
        addVec(0, 16'hC000, 1, 0, 3'd3, PCL,               16'd4);
        addVec(0, 16'hC000, 0, 1, 3'd1, FTCH,              16'd5);
        addVec(0, 16'hC000, 0, 0, 3'd2, 15'h0,             16'd5);
        addVec(0, 16'hC000, 0, 0, 3'd3, 15'h0,             16'd5);
        addVec(0, 16'hD000, 0, 1, 3'd1, FTCH,              16'd6);
        addVec(0, 16'hD000, 0, 0, 3'd2, 15'h0,             16'd6);
        addVec(0, 16'hD000, 0, 0, 3'd3, PCL,               16'd6);
        addVec(0, 16'hE000, 0, 1, 3'd1, FTCH,              16'd7);
        addVec(0, 16'hE000, 0, 0, 3'd2, 15'h0,             16'd7);
        addVec(1, 16'hF000, 0, 1, 3'd1, FTCH,              16'd8);
        addVec(1, 16'hF000, 0, 0, 3'd2, 15'h0,             16'd8);
        addVec(1, 16'hF000, 0, 0, 3'd6, HLT,               16'd9);
        addVec(1, 16'hF000, 0, 0, 3'd6, HLT,               16'd9);
        addVec(0, 16'hF000, 0, 0, 3'd6, HLT,               16'd9);
        addVec(1, 16'hF000, 0, 0, 3'd6, HLT,               16'd9);
        addVec(1, 16'h0000, 0, 0, 3'd1, MREQ,              16'd9);

        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].run, vq[i].instr, vq[i].flag_z, vq[i].mem_ready);
            checkOutput("vec_state",   i, 32'(state),    32'(vq[i].state));
            checkOutput("vec_outs",    i, 32'(dut_outs), 32'(vq[i].outs));
            checkOutput("vec_retired", i, 32'(retired),  32'(expRetired(vq[i].ret)));
        end

        // Reset asserted mid-fetch while mem_ready is high.
        doReset();
        applyStimulus(1, 16'h1234, 0, 0);
        applyStimulus(0, 16'h1234, 0, 1);
        checkOutput("midrst_pre_irload", 0, 32'(ir_load), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_state",   0, 32'(state),    32'd0);
        checkOutput("midrst_outs",    0, 32'(dut_outs), 32'd0);
        checkOutput("midrst_retired", 0, 32'(retired),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 16'h1234, 0, 1);
        checkOutput("midrst_stay_idle", 0, 32'(state), 32'd0);

        // Fresh HALT retires exactly one instruction.
        doReset();
        applyStimulus(1, 16'hF000, 0, 1);
        applyStimulus(0, 16'hF000, 0, 1);
        checkOutput("halt_fetch", 0, 32'(state), 32'd1);
        applyStimulus(0, 16'hF000, 0, 0);
        checkOutput("halt_decode", 0, 32'(state), 32'd2);
        applyStimulus(0, 16'hF000, 0, 0);
        checkOutput("halt_state",   0, 32'(state),   32'd6);
        checkOutput("halt_halted",  0, 32'(halted),  32'd1);
        checkOutput("halt_retired", 0, 32'(retired), 32'(expRetired(16'd1)));

        // Fetch timeout: counter reaches 8 after eight idle cycles, fault on the next edge.
        doReset();
        applyStimulus(1, 16'hE000, 0, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 16'hE000, 0, 0);
            checkOutput("tmo_wait_state", i, 32'(state),   32'd1);
            checkOutput("tmo_wait_mreq",  i, 32'(mem_req), 32'd1);
        end
        applyStimulus(0, 16'hE000, 0, 0);
        checkOutput("tmo_fault_state", 0, 32'(state),    32'd7);
        checkOutput("tmo_fault_outs",  0, 32'(dut_outs), 32'h1);
        applyStimulus(1, 16'hE000, 0, 1);
        applyStimulus(1, 16'hE000, 0, 1);
        checkOutput("tmo_run_ignored", 0, 32'(state), 32'd7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("tmo_reset_state", 0, 32'(state), 32'd0);
        checkOutput("tmo_reset_fault", 0, 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Handshake in the cycle the counter sits at its limit wins over the fault.
        doReset();
        applyStimulus(1, 16'hE000, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 16'hE000, 0, 0);
        end
        applyStimulus(0, 16'hE000, 0, 1);
        checkOutput("race_state",  0, 32'(state),   32'd1);
        checkOutput("race_irload", 0, 32'(ir_load), 32'd1);
        applyStimulus(0, 16'hE000, 0, 0);
        checkOutput("race_decode", 0, 32'(state), 32'd2);
        applyStimulus(0, 16'hE000, 0, 0);
        checkOutput("race_refetch", 0, 32'(state), 32'd1);
        checkOutput("race_nofault", 0, 32'(fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8: cycles allowed for mem_ready after mem_req asserts; 0 disables timeout.
REQ-002 clk  in  1  single system clock, rising-edge; reset is asynchronous and active-low.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 run  in  1  start/resume request, rising-edge detected internally.
REQ-005 instr  in  16  current IR word: OP=[15:12], DEST=[11:9], Q0=[8:6], Q1=[5:3], IMM=[5:2], flag_en=[1], immed_sel=[0].
REQ-006 flag_z  in  1  ALU zero flag (registered outside this block).
REQ-007 mem_ready  in  1  memory handshake complete.
REQ-008 mem_req / mem_we / mem_addr_sel  out  1 each  memory request, write strobe, address source (0=PC, 1=register Q0).
REQ-009 ir_load / pc_inc / pc_load  out  1 each  IR capture, PC+1, PC load from register Q0.
REQ-010 reg_we / flag_we / alu_src_imm  out  1 each  register write (DEST), flag update, ALU B from IMM.
REQ-011 alu_op  out  4  ALU opcode; halted / fault  out  1 each; state  out  3; retired  out  16.

Function
REQ-012 Opcode map SHALL be 0x0-0x9 ALU, 0xA LOAD, 0xB STORE, 0xC BRZ, 0xD JMP, 0xE NOP, 0xF HALT.
REQ-013 States/encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7; state output = current encoding.
REQ-014 IDLE: all strobes 0; run rising edge -> FETCH.
REQ-015 FETCH: mem_req=1, mem_addr_sel=0; cycle with mem_ready=1 asserts ir_load=1 and pc_inc=1 (combinational on mem_ready) -> DECODE.
REQ-016 DECODE: one cycle, no strobes; OP=0xF -> HALT, OP=0xE -> FETCH, else -> EXEC.
REQ-017 EXEC, ALU op: alu_op=OP, alu_src_imm=instr[0], flag_we=instr[1] -> WB.
REQ-018 EXEC, LOAD/STORE: -> MEM; BRZ: pc_load=flag_z -> FETCH; JMP: pc_load=1 -> FETCH.
REQ-019 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE; on mem_ready LOAD -> WB, STORE -> FETCH.
REQ-020 WB: reg_we=1 for exactly one cycle -> FETCH.
REQ-021 Latency without wait states: ALU 4 cycles, LOAD 5, STORE 4, BRZ/JMP 3, NOP 2.
REQ-022 Timeout counter SHALL count consecutive cycles in FETCH/MEM with mem_ready=0, clear on handshake or state exit; reaching MEM_TIMEOUT -> FAULT next edge.
REQ-023 mem_ready in the same cycle the counter reaches MEM_TIMEOUT SHALL win (handshake completes, no FAULT).
REQ-024 HALT: halted=1, strobes 0; run rising edge -> FETCH; run level high without new edge SHALL NOT resume.
REQ-025 FAULT: fault=1, all strobes 0; exit only via rst_n.
REQ-026 run changes outside IDLE/HALT SHALL be ignored; instructions always complete.
REQ-027 instr SHALL be sampled only in DECODE/EXEC/MEM/WB; upstream holds IR stable after ir_load.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, timeout counter=0, run edge detector=0, retired=0, all outputs 0.
REQ-029 Reset mid-handshake SHALL drop mem_req in the same cycle with no pc_inc or ir_load.

Configuration
REQ-030 Macro SEQ_PERF_CNT_EN defined: retired increments by 1 on each completed instruction (leaving WB, EXEC for BRZ/JMP, MEM for STORE, DECODE for NOP/HALT), wrapping 0xFFFF->0x0000.
REQ-031 SEQ_PERF_CNT_EN undefined: retired tied to 0, counter logic absent.

Verification
REQ-032 Reset, run pulse, instr=0x1234 (ALU op1, flag_en=0, immed_sel=0), mem_ready=1 -> states 1,2,3,5,1; reg_we one cycle; alu_op=0x1; flag_we=0.
REQ-033 instr=0xA000 LOAD, mem_ready delayed 3 cycles in MEM -> mem_req/mem_addr_sel high 4 cycles, then WB with reg_we=1, no FAULT.
REQ-034 MEM_TIMEOUT=8, mem_ready held 0 in FETCH -> FAULT after 8 cycles, fault=1, later run edge ignored, rst_n clears it.
REQ-035 instr=0xC000 BRZ with flag_z=1 then flag_z=0 -> pc_load=1 first pass, 0 second; each 3 cycles.
REQ-036 instr=0xF000 -> halted=1; run held high no resume; run 0->1 -> FETCH; with SEQ_PERF_CNT_EN, retired=1 after HALT.
REQ-037 rst_n asserted mid-FETCH with mem_ready=1 same cycle -> no ir_load/pc_inc, state=0 immediately.
